// File: rtl/spu_lsu_ldst_rcv.sv
// Purpose : LSU-side receiver that queues SPU ld/st packets in a DEPTH-entry FIFO and returns one credit per dequeue.
// Latency : a push in cycle N shows on lsu_ldst_pckt_vld in cycle N+1 (no bypass); credit pulses the cycle after a pop.
// Backpr. : the LSU stalls the head packet with ack=0; the SPU is credit-limited, and a push into a full FIFO without a pop is dropped with a sticky error.
//
// Ports:
//   rclk, reset               core clock, asynchronous active-high reset
//   spu_lsu_ldst_pckt_vld/_pckt   incoming packet from the SPU (one per valid cycle)
//   lsu_spu_ldst_credit       one-cycle credit-return pulse to the SPU
//   lsu_ldst_pckt_vld/_pckt   head packet toward the LSU (data is zero when empty)
//   lsu_ldst_pckt_ack         LSU takes the head packet this cycle
//   lsu_ldst_rcv_ovfl_err     sticky overflow flag
//   lsu_ldst_rcv_cnt          current occupancy, 0..DEPTH
module spu_lsu_ldst_rcv #(
   parameter int PW    = 123,
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic            rclk,
   input  logic            reset,
   input  logic            spu_lsu_ldst_pckt_vld,
   input  logic [PW-1:0]   spu_lsu_ldst_pckt,
   output logic            lsu_spu_ldst_credit,
   output logic            lsu_ldst_pckt_vld,
   output logic [PW-1:0]   lsu_ldst_pckt,
   input  logic            lsu_ldst_pckt_ack,
   output logic            lsu_ldst_rcv_ovfl_err,
   output logic [PTRW:0]   lsu_ldst_rcv_cnt
);

   localparam logic [PTRW:0]   L_FULL    = (PTRW+1)'(DEPTH);
   localparam logic [PTRW:0]   L_CNT_ONE = (PTRW+1)'(1);
   localparam logic [PTRW-1:0] L_PTR_ONE = PTRW'(1);

   logic [PW-1:0]   r_mem [DEPTH];
   logic [PTRW-1:0] r_wr_ptr;
   logic [PTRW-1:0] r_rd_ptr;
   logic [PTRW:0]   r_cnt;
   logic            r_credit;
   logic            r_ovfl_err;

   logic            w_vld;
   logic            w_full;
   logic            w_pop;
   logic            w_push_ok;
   logic            w_drop;

   assign w_vld     = (r_cnt != '0);
   assign w_full    = (r_cnt == L_FULL);
   // An ack with nothing valid is simply ignored.
   assign w_pop     = w_vld & lsu_ldst_pckt_ack;
   // When full, a same-cycle pop frees the head slot, so the push still fits.
   assign w_push_ok = spu_lsu_ldst_pckt_vld & (~w_full | w_pop);
   assign w_drop    = spu_lsu_ldst_pckt_vld & w_full & ~w_pop;

   // Packet storage carries no reset; validity is tracked entirely by r_cnt.
   always_ff @(posedge rclk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= spu_lsu_ldst_pckt;
      end
   end

   always_ff @(posedge rclk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_credit   <= 1'b0;
         r_ovfl_err <= 1'b0;
      end else begin
         // Pointers are exactly PTRW bits wide, so +1 wraps modulo DEPTH.
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
         end
         if (w_push_ok & ~w_pop) begin
            r_cnt <= r_cnt + L_CNT_ONE;
         end else if (w_pop & ~w_push_ok) begin
            r_cnt <= r_cnt - L_CNT_ONE;
         end
         r_credit <= w_pop;
         if (w_drop) begin
            r_ovfl_err <= 1'b1;
         end
      end
   end

   // All outputs come from registered state only.
   assign lsu_ldst_pckt_vld     = w_vld;
   assign lsu_ldst_pckt         = w_vld ? r_mem[r_rd_ptr] : '0;
   assign lsu_spu_ldst_credit   = r_credit;
   assign lsu_ldst_rcv_ovfl_err = r_ovfl_err;
   assign lsu_ldst_rcv_cnt      = r_cnt;

endmodule

// File: tb/tb_spu_lsu_ldst_rcv.sv
`timescale 1ns/1ps
// Purpose : scoreboard bench for spu_lsu_ldst_rcv; a queue model of the FIFO predicts every output each cycle.
// Latency : inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Backpr. : the random phase obeys the SPU credit protocol; directed phases exercise stall, full and overflow.
module tb_spu_lsu_ldst_rcv;

   localparam int PW    = 123;
   localparam int DEPTH = 4;
   localparam int PTRW  = 2;

   logic            rclk = 1'b0;
   logic            reset = 1'b1;
   logic            in_vld = 1'b0;
   logic [PW-1:0]   in_pckt = '0;
   logic            ack = 1'b0;
   logic            credit;
   logic            out_vld;
   logic [PW-1:0]   out_pckt;
   logic            err;
   logic [PTRW:0]   cnt;

   always #5 rclk = ~rclk;

   spu_lsu_ldst_rcv #(.PW(PW), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
      .rclk                  (rclk),
      .reset                 (reset),
      .spu_lsu_ldst_pckt_vld (in_vld),
      .spu_lsu_ldst_pckt     (in_pckt),
      .lsu_spu_ldst_credit   (credit),
      .lsu_ldst_pckt_vld     (out_vld),
      .lsu_ldst_pckt         (out_pckt),
      .lsu_ldst_pckt_ack     (ack),
      .lsu_ldst_rcv_ovfl_err (err),
      .lsu_ldst_rcv_cnt      (cnt)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: packets the FIFO should hold, head first.
   logic [PW-1:0] exp_q[$];
   logic          m_err    = 1'b0;
   logic          m_credit = 1'b0;
   int            spu_credits  = DEPTH;
   int            pops_seen    = 0;
   int            credits_seen = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] rnd_pkt();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[PW-1:0];
   endfunction

   task automatic drive(input bit p, input logic [PW-1:0] d, input bit a);
      @(posedge rclk);
      #1;
      in_vld  = p;
      in_pckt = d;
      ack     = a;
   endtask

   // Monitor: compare outputs against the model, then advance the model by this cycle's inputs.
   always @(negedge rclk) begin : mon
      int sz;
      bit pop;
      bit acc;
      if (!reset) begin
         sz = exp_q.size();
         chk("vld", out_vld, sz != 0);
         chk("cnt", cnt, sz);
         chk("err", err, m_err);
         chk("credit", credit, m_credit);
         chk("pckt", out_pckt, (sz != 0) ? exp_q[0] : '0);
         if (credit) begin
            credits_seen++;
            spu_credits++;
         end
         pop = (sz != 0) && ack;
         if (pop) begin
            void'(exp_q.pop_front());
            pops_seen++;
         end
         acc = in_vld && ((sz < DEPTH) || pop);
         if (acc) exp_q.push_back(in_pckt);
         else if (in_vld) m_err = 1'b1;
         m_credit = pop;
      end
   end

   initial begin : stim
      logic [PW-1:0] p1;
      reset = 1'b1;
      repeat (2) @(posedge rclk);
      #2 reset = 1'b0;

      // Single packet with ack held high.
      p1 = 1;
      drive(1, p1, 1);
      drive(0, '0, 1);
      drive(0, '0, 1);
      drive(0, '0, 0);

      // Fill and stall, then drain back to back.
      for (int k = 0; k < DEPTH; k++) drive(1, rnd_pkt(), 0);
      repeat (10) drive(0, '0, 0);
      repeat (6) drive(0, '0, 1);
      drive(0, '0, 0);

      // Full with simultaneous pop.
      for (int k = 0; k < DEPTH; k++) drive(1, rnd_pkt(), 0);
      drive(1, rnd_pkt(), 1);
      repeat (7) drive(0, '0, 1);
      drive(0, '0, 0);

      // Overflow: push into a full FIFO without a pop.
      for (int k = 0; k < DEPTH; k++) drive(1, rnd_pkt(), 0);
      drive(1, rnd_pkt(), 0);
      repeat (3) drive(0, '0, 0);
      repeat (6) drive(0, '0, 1);
      repeat (2) drive(0, '0, 0);

      // Reset mid-cycle with three packets queued; outputs clear without a clock edge.
      for (int k = 0; k < 3; k++) drive(1, rnd_pkt(), 0);
      drive(0, '0, 0);
      @(posedge rclk);
      #3 reset = 1'b1;
      #1;
      chk("rst_vld", out_vld, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_credit", credit, 0);
      chk("rst_err", err, 0);
      chk("rst_pckt", out_pckt, 0);
      exp_q.delete();
      m_err    = 1'b0;
      m_credit = 1'b0;
      @(posedge rclk);
      #2;
      spu_credits  = DEPTH;
      pops_seen    = 0;
      credits_seen = 0;
      reset = 1'b0;

      // Random traffic obeying the credit protocol.
      for (int i = 0; i < 1000; i++) begin
         bit p;
         @(posedge rclk);
         #1;
         p = (spu_credits > 0) && ($urandom_range(3) != 0);
         if (p) spu_credits--;
         in_vld  = p;
         in_pckt = p ? rnd_pkt() : '0;
         ack     = ($urandom_range(3) != 0);
      end
      repeat (12) drive(0, '0, 1);
      drive(0, '0, 0);
      @(negedge rclk);
      #1;
      chk("credits_eq_pops", credits_seen, pops_seen);
      chk("ptr_wraps_ge_100", (pops_seen / DEPTH) >= 100, 1);
      chk("final_empty", cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
